// File: rtl/imm_extend_pipe.sv
// Two-stage immediate extender: stage 1 captures {imm, mode}, stage 2 holds
// the extended result. Both stages use valid/ready so back-pressure is absorbed.
module imm_extend_pipe #(
  parameter int IN_W  = 8,
  parameter int OUT_W = 32,
  parameter int SHIFT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_imm,
  output logic             out_lost
);

  localparam int EXT_W = OUT_W + SHIFT;

  logic             s1_valid_q, s1_valid_d;
  logic [IN_W-1:0]  s1_imm_q, s1_imm_d;
  logic [1:0]       s1_mode_q, s1_mode_d;
  logic             s2_valid_q, s2_valid_d;
  logic [OUT_W-1:0] out_imm_q, out_imm_d;
  logic             out_lost_q, out_lost_d;

  logic             s2_load;
  logic             in_fire;
  logic [OUT_W-1:0] ext_zero;
  logic [OUT_W-1:0] ext_sign;
  logic [OUT_W-1:0] ext_upper;
  logic [EXT_W-1:0] scaled_full;
  logic             scaled_lost;

  assign s2_load = s1_valid_q && (!s2_valid_q || out_ready);
  assign in_ready = !s1_valid_q || s2_load;
  assign in_fire = in_valid && in_ready;

  assign ext_zero    = OUT_W'(s1_imm_q);
  assign ext_upper   = ext_zero << (OUT_W - IN_W);
  assign scaled_full = EXT_W'(s1_imm_q) << SHIFT;

  generate
    if (OUT_W > IN_W) begin : g_sext
      assign ext_sign = {{(OUT_W - IN_W){s1_imm_q[IN_W-1]}}, s1_imm_q};
    end else begin : g_sext_same
      assign ext_sign = s1_imm_q;
    end
  endgenerate

  // Bits above OUT_W only exist when the scale shift is nonzero.
  generate
    if (SHIFT > 0) begin : g_lost
      assign scaled_lost = |scaled_full[EXT_W-1:OUT_W];
    end else begin : g_no_lost
      assign scaled_lost = 1'b0;
    end
  endgenerate

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_imm_d   = s1_imm_q;
    s1_mode_d  = s1_mode_q;
    if (in_fire) begin
      s1_valid_d = 1'b1;
      s1_imm_d   = in_imm;
      s1_mode_d  = in_mode;
    end else if (s2_load) begin
      s1_valid_d = 1'b0;
    end
  end

  always_comb begin
    s2_valid_d = s2_valid_q;
    out_imm_d  = out_imm_q;
    out_lost_d = out_lost_q;
    if (s2_load) begin
      s2_valid_d = 1'b1;
      out_lost_d = 1'b0;
      case (s1_mode_q)
        2'b00: out_imm_d = ext_zero;
        2'b01: out_imm_d = ext_sign;
        2'b10: begin
          out_imm_d  = scaled_full[OUT_W-1:0];
          out_lost_d = scaled_lost;
        end
        default: out_imm_d = ext_upper;
      endcase
    end else if (out_ready) begin
      s2_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_imm_q   <= '0;
      s1_mode_q  <= '0;
      s2_valid_q <= 1'b0;
      out_imm_q  <= '0;
      out_lost_q <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_imm_q   <= s1_imm_d;
      s1_mode_q  <= s1_mode_d;
      s2_valid_q <= s2_valid_d;
      out_imm_q  <= out_imm_d;
      out_lost_q <= out_lost_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_imm   = out_imm_q;
  assign out_lost  = out_lost_q;

endmodule

// File: doc/imm_extend_pipe.md
Name: imm_extend_pipe

Overview:
Parametrised, pipelined immediate extender for the datapath decode stage. Widens an IN_W-bit instruction immediate to OUT_W bits in one of four modes: zero, sign, scaled-zero, upper. Two-stage registered pipeline with valid/ready handshakes on both sides, so it can sit between the instruction decoder and the operand/ALU stage and absorb back-pressure.

Parameters:
IN_W, 8, immediate input width (1 <= IN_W <= OUT_W)
OUT_W, 32, extended output width
SHIFT, 2, left-shift amount applied in scaled mode (0 <= SHIFT < OUT_W)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-high
in_valid  input  1  upstream has an immediate
in_ready  output  1  block accepts this cycle
in_imm  input  IN_W  raw immediate
in_mode  input  2  00 zero, 01 sign, 10 scaled-zero, 11 upper
out_valid  output  1  out_imm/out_lost valid
out_ready  input  1  downstream accepts
out_imm  output  OUT_W  extended immediate
out_lost  output  1  scaled mode dropped nonzero bits

Behaviour:
- Reset (async assert, sync release on clk): s1_valid=0, s2_valid=0, out_valid=0, out_imm=0, out_lost=0, internal data regs=0. in_ready becomes 1 after reset because the pipe is empty.
- Stage 1 registers {in_imm, in_mode}. Stage 2 computes the result and registers it to out_imm/out_lost. out_valid = s2_valid.
- Transfer rules: input handshake when in_valid && in_ready; output handshake when out_valid && out_ready.
- s2_load = s1_valid && (!s2_valid || out_ready). in_ready = !s1_valid || s2_load. Combinational path out_ready -> in_ready is allowed.
- Latency: 2 cycles from input handshake to out_valid with no stall. Throughput: 1 per cycle while out_ready=1.
- While out_valid=1 && out_ready=0, out_imm/out_lost hold stable. Stage 1 holds once full. No data is dropped or duplicated.
- Mode 00: out = {(OUT_W-IN_W) zeros, imm}.
- Mode 01: out = {(OUT_W-IN_W) copies of imm[IN_W-1], imm}. If IN_W == OUT_W, out = imm.
- Mode 10: out = zero_ext(imm) << SHIFT, truncated to OUT_W. out_lost=1 iff any bit shifted beyond bit OUT_W-1 was 1. This is only possible when IN_W+SHIFT > OUT_W.
- Mode 11: out = imm << (OUT_W-IN_W), with imm in the top bits and zeros below.
- out_lost=0 in every mode other than 10.
- Simultaneous output handshake and new input on a full pipe: s2 takes s1, s1 takes the input in the same edge, and throughput is preserved.
- Reset asserted mid-operation: all in-flight entries are discarded immediately and outputs go to their reset values. No handshake completes on that edge.
- in_mode and in_imm are sampled only on an input handshake. Values while in_valid=0 are ignored.

Test Plan:
1. Default params, out_ready=1, back-to-back inputs (0xFF,00), (0xFF,01), (0x40,01), (0x1F,10), (0x80,11) -> two cycles later, on consecutive cycles, outputs 0x000000FF, 0xFFFFFFFF, 0x00000040, 0x0000007C, 0x80000000. out_lost=0 throughout.
2. Back-pressure: load (0x7F,01) and (0x81,01), hold out_ready=0 for 5 cycles -> out_imm stays 0x0000007F with out_valid=1; in_ready=0 once both stages are full. Then release out_ready -> 0xFFFFFF81 follows on the next cycle with no loss.
3. Full-pipe simultaneous handshake: with both stages full, set out_ready=1 and in_valid=1 with (0x01,00) -> same edge moves the pipe. Outputs appear in order with no bubble.
4. IN_W=8, OUT_W=9, SHIFT=2, input (0xC0,10) -> out_imm=0x100, out_lost=1. Input (0x3F,10) -> out_imm=0x0FC, out_lost=0.
5. Reset mid-operation: assert rst asynchronously between clock edges while two entries are in flight -> out_valid=0 and out_imm=0 immediately. After release the pipe is empty and the first new input emerges after 2 cycles.
6. IN_W=OUT_W=16, mode 01 input 0x8001 -> out_imm=0x8001. Mode 11 input 0x8001 -> out_imm=0x8001.
